// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Time-multiplexed multi-digit 7-segment display driver.
//               Packed nibbles are decoded one digit at a time onto a shared
//               segment bus with a one-hot digit enable.  Supports hex or
//               decimal-only decode, leading-zero blanking, per-digit
//               decimal points, frame-synchronous double buffering and a
//               dead time at the start of every digit slot.
// Ports       : i_Clk        - system clock
//               i_Rst        - asynchronous active-high reset
//               i_Value      - NUM_DIGITS packed nibbles, nibble 0 rightmost
//               i_Dp         - decimal point per digit
//               i_Load       - capture i_Value/i_Dp into the shadow register
//               i_Hex_En     - 1: show A-F, 0: blank codes 10-15
//               i_Blank_Lz   - 1: blank leading zeros (never digit 0)
//               o_Segments   - segments, bit6 = A ... bit0 = G
//               o_Dp         - decimal point of the active digit
//               o_Digit_En   - one-hot digit enable
//               o_Frame_Done - one-cycle pulse after each frame boundary
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 25000,
    parameter int DEAD_CLKS      = 250,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic [4*NUM_DIGITS-1:0]   i_Value,
    input  logic [NUM_DIGITS-1:0]     i_Dp,
    input  logic                      i_Load,
    input  logic                      i_Hex_En,
    input  logic                      i_Blank_Lz,
    output logic [6:0]                o_Segments,
    output logic                      o_Dp,
    output logic [NUM_DIGITS-1:0]     o_Digit_En,
    output logic                      o_Frame_Done
);

    localparam int c_PW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
    localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_PW-1:0] c_P_LAST  = c_PW'(CLKS_PER_DIGIT - 1);
    localparam logic [c_IW-1:0] c_I_LAST  = c_IW'(NUM_DIGITS - 1);
    localparam logic            c_SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic            c_DIG_INV = (DIG_ACTIVE_LOW != 0);

    logic [c_PW-1:0]           r_presc;
    logic [c_IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0]   r_shadow_val;
    logic [NUM_DIGITS-1:0]     r_shadow_dp;
    logic [4*NUM_DIGITS-1:0]   r_disp_val;
    logic [NUM_DIGITS-1:0]     r_disp_dp;

    logic                      w_p_wrap;
    logic                      w_frame_edge;
    logic                      w_live;
    logic                      w_acc;
    logic [NUM_DIGITS-1:0]     w_zero_run;
    logic [3:0]                w_nib;
    logic                      w_dp_sel;
    logic                      w_lz_blank;
    logic [NUM_DIGITS-1:0]     w_en_raw;
    logic [6:0]                w_seg_raw;
    logic [6:0]                w_seg;

    assign w_p_wrap     = (r_presc == c_P_LAST);
    assign w_frame_edge = w_p_wrap && (r_idx == c_I_LAST);

    // Digits stay dark for the first DEAD_CLKS clocks of each slot so the
    // previous digit's segments never ghost onto the next digit.
    generate
        if (DEAD_CLKS == 0) begin : g_no_dead
            assign w_live = 1'b1;
        end else begin : g_dead
            assign w_live = (r_presc >= c_PW'(DEAD_CLKS));
        end
    endgenerate

    // Scan counters: prescaler within a slot, digit index across slots.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_p_wrap) begin
            r_presc <= '0;
            r_idx   <= (r_idx == c_I_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Double buffer: loads go to the shadow copy, which is only transferred
    // to the display copy at the frame boundary so a frame is never torn.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_disp_val   <= '0;
            r_disp_dp    <= '0;
        end else begin
            if (i_Load) begin
                r_shadow_val <= i_Value;
                r_shadow_dp  <= i_Dp;
            end
            if (w_frame_edge) begin
                r_disp_val <= r_shadow_val;
                r_disp_dp  <= r_shadow_dp;
            end
        end
    end

    // w_zero_run[k] is set when display nibbles NUM_DIGITS-1 down to k are
    // all zero, i.e. digit k is a leading zero.
    always_comb begin
        w_zero_run = '0;
        w_acc      = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_acc         = w_acc && (r_disp_val[4*k +: 4] == 4'd0);
            w_zero_run[k] = w_acc;
        end
    end

    // Select the active digit's nibble, DP, blanking state and enable.
    always_comb begin
        w_nib      = '0;
        w_dp_sel   = 1'b0;
        w_lz_blank = 1'b0;
        w_en_raw   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == c_IW'(k)) begin
                w_nib       = r_disp_val[4*k +: 4];
                w_dp_sel    = r_disp_dp[k];
                w_lz_blank  = (k != 0) && i_Blank_Lz && w_zero_run[k];
                w_en_raw[k] = w_live;
            end
        end
    end

    // Active-high segment decode, A in bit 6 down to G in bit 0.
    always_comb begin
        w_seg_raw = 7'b0000000;
        case (w_nib)
            4'h0: w_seg_raw = 7'b1111110;
            4'h1: w_seg_raw = 7'b0110000;
            4'h2: w_seg_raw = 7'b1101101;
            4'h3: w_seg_raw = 7'b1111001;
            4'h4: w_seg_raw = 7'b0110011;
            4'h5: w_seg_raw = 7'b1011011;
            4'h6: w_seg_raw = 7'b1011111;
            4'h7: w_seg_raw = 7'b1110000;
            4'h8: w_seg_raw = 7'b1111111;
            4'h9: w_seg_raw = 7'b1111011;
            4'hA: w_seg_raw = i_Hex_En ? 7'b1110111 : 7'b0000000;
            4'hB: w_seg_raw = i_Hex_En ? 7'b0011111 : 7'b0000000;
            4'hC: w_seg_raw = i_Hex_En ? 7'b1001110 : 7'b0000000;
            4'hD: w_seg_raw = i_Hex_En ? 7'b0111101 : 7'b0000000;
            4'hE: w_seg_raw = i_Hex_En ? 7'b1001111 : 7'b0000000;
            4'hF: w_seg_raw = i_Hex_En ? 7'b1000111 : 7'b0000000;
            default: w_seg_raw = 7'b0000000;
        endcase
        w_seg = w_lz_blank ? 7'b0000000 : w_seg_raw;
    end

    // Registered output stage; board polarity is applied here and nowhere
    // else so all internal logic stays active-high.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_Segments   <= {7{c_SEG_INV}};
            o_Dp         <= c_SEG_INV;
            o_Digit_En   <= {NUM_DIGITS{c_DIG_INV}};
            o_Frame_Done <= 1'b0;
        end else begin
            o_Segments   <= w_seg ^ {7{c_SEG_INV}};
            o_Dp         <= w_dp_sel ^ c_SEG_INV;
            o_Digit_En   <= w_en_raw ^ {NUM_DIGITS{c_DIG_INV}};
            o_Frame_Done <= w_frame_edge;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_driver
// Description : Directed self-checking bench for seven_seg_scan_driver with
//               4 digits, 4 clocks per digit and 1 dead clock per slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_driver;

    logic        i_Clk      = 1'b0;
    logic        i_Rst      = 1'b0;
    logic [15:0] i_Value    = '0;
    logic [3:0]  i_Dp       = '0;
    logic        i_Load     = 1'b0;
    logic        i_Hex_En   = 1'b0;
    logic        i_Blank_Lz = 1'b0;
    logic [6:0]  o_Segments;
    logic        o_Dp;
    logic [3:0]  o_Digit_En;
    logic        o_Frame_Done;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS     (4),
        .CLKS_PER_DIGIT (4),
        .DEAD_CLKS      (1),
        .SEG_ACTIVE_LOW (0),
        .DIG_ACTIVE_LOW (1)
    ) u_dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Value      (i_Value),
        .i_Dp         (i_Dp),
        .i_Load       (i_Load),
        .i_Hex_En     (i_Hex_En),
        .i_Blank_Lz   (i_Blank_Lz),
        .o_Segments   (o_Segments),
        .o_Dp         (o_Dp),
        .o_Digit_En   (o_Digit_En),
        .o_Frame_Done (o_Frame_Done)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return on the falling edge for drive/sample.
    task automatic tick();
        @(posedge i_Clk);
        @(negedge i_Clk);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        i_Value = v;
        i_Dp    = d;
        i_Load  = 1'b1;
        tick();
        i_Load  = 1'b0;
    endtask

    task automatic wait_frame_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (o_Frame_Done === 1'b1) seen = 1'b1;
        end
        chk("frame_done_seen", {31'd0, seen}, 32'd1);
    endtask

    // Checks one whole frame starting right after a frame-done sample.
    // Optional loads: value va at step la, value vb at step lb (-1 = none).
    task automatic check_frame(input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0,
                               input logic [3:0] dp,
                               input int la, input logic [15:0] va,
                               input int lb, input logic [15:0] vb);
        logic [6:0] segs [4];
        logic [3:0] onehot;
        logic [3:0] exp_en;
        int idx;
        int p;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int j = 0; j < 16; j++) begin
            idx = j / 4;
            p   = j % 4;
            if (j == la) begin
                i_Value = va; i_Load = 1'b1;
            end else if (j == lb) begin
                i_Value = vb; i_Load = 1'b1;
            end
            tick();
            i_Load = 1'b0;
            onehot = 4'b0001 << idx;
            exp_en = (p == 0) ? 4'b1111 : ~onehot;
            chk($sformatf("seg d%0d p%0d", idx, p), {25'd0, o_Segments}, {25'd0, segs[idx]});
            chk($sformatf("dp d%0d p%0d", idx, p), {31'd0, o_Dp}, {31'd0, dp[idx]});
            chk($sformatf("en d%0d p%0d", idx, p), {28'd0, o_Digit_En}, {28'd0, exp_en});
            chk($sformatf("fd d%0d p%0d", idx, p), {31'd0, o_Frame_Done}, {31'd0, (j == 15)});
        end
    endtask

    initial begin
        // Reset state, held for 10 clocks.
        #1 i_Rst = 1'b1;
        #1;
        chk("rst seg", {25'd0, o_Segments}, 32'h0);
        chk("rst dp", {31'd0, o_Dp}, 32'h0);
        chk("rst en", {28'd0, o_Digit_En}, 32'hF);
        chk("rst fd", {31'd0, o_Frame_Done}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst hold seg", {25'd0, o_Segments}, 32'h0);
            chk("rst hold en", {28'd0, o_Digit_En}, 32'hF);
            chk("rst hold fd", {31'd0, o_Frame_Done}, 32'h0);
        end
        i_Rst = 1'b0;

        // Decimal mode, 1234 with DP on digit 2.
        i_Hex_En = 1'b0; i_Blank_Lz = 1'b0;
        load(16'h1234, 4'b0100);
        wait_frame_done();
        check_frame(7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 4'b0100,
                    -1, 16'h0, -1, 16'h0);

        // Hex mode, ABCD.
        i_Hex_En = 1'b1;
        load(16'hABCD, 4'b0000);
        wait_frame_done();
        check_frame(7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 4'b0000,
                    -1, 16'h0, -1, 16'h0);

        // Decimal-only mode blanks A-F; enables keep cycling.
        i_Hex_En = 1'b0;
        check_frame(7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0000,
                    -1, 16'h0, -1, 16'h0);

        // Leading-zero blanking.
        i_Blank_Lz = 1'b1;
        load(16'h0050, 4'b0000);
        wait_frame_done();
        check_frame(7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110, 4'b0000,
                    -1, 16'h0, -1, 16'h0);
        load(16'h0000, 4'b1000);
        wait_frame_done();
        check_frame(7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110, 4'b1000,
                    -1, 16'h0, -1, 16'h0);

        // Double buffering: mid-frame load and load on the boundary edge.
        i_Blank_Lz = 1'b0;
        i_Hex_En   = 1'b1;
        i_Dp       = 4'b0000;
        check_frame(7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'b1000,
                    5, 16'h1111, 15, 16'h2222);
        check_frame(7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000, 4'b0000,
                    -1, 16'h0, -1, 16'h0);
        check_frame(7'b1101101, 7'b1101101, 7'b1101101, 7'b1101101, 4'b0000,
                    -1, 16'h0, -1, 16'h0);

        // Async reset mid-slot (digit 2, p = 2) without a clock edge.
        for (int i = 0; i < 10; i++) tick();
        chk("pre-rst en", {28'd0, o_Digit_En}, 32'hB);
        #2 i_Rst = 1'b1;
        #1;
        chk("async seg", {25'd0, o_Segments}, 32'h0);
        chk("async dp", {31'd0, o_Dp}, 32'h0);
        chk("async en", {28'd0, o_Digit_En}, 32'hF);
        chk("async fd", {31'd0, o_Frame_Done}, 32'h0);
        tick();
        i_Rst = 1'b0;
        tick();
        chk("post-rst clk1 en", {28'd0, o_Digit_En}, 32'hF);
        chk("post-rst clk1 seg", {25'd0, o_Segments}, {25'd0, 7'b1111110});
        tick();
        chk("post-rst clk2 en", {28'd0, o_Digit_En}, 32'hE);
        chk("post-rst clk2 seg", {25'd0, o_Segments}, {25'd0, 7'b1111110});
        wait_frame_done();
        check_frame(7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'b0000,
                    -1, 16'h0, -1, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
Parametrised multi-digit 7-segment display driver, successor to the single-digit binary-to-segment decoder. It takes a packed NUM_DIGITS x 4-bit value and time-multiplexes it onto one shared segment bus with per-digit enables. Features: hex or decimal-only decode, leading-zero blanking, per-digit decimal points, frame-synchronous double-buffered updates and anti-ghosting dead time. Sits between UART/debug logic and the board's display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=1)
CLKS_PER_DIGIT, 25000, clocks per digit slot (>=2)
DEAD_CLKS, 250, clocks at slot start with all digits off (0 <= DEAD_CLKS < CLKS_PER_DIGIT)
SEG_ACTIVE_LOW, 0, 1 = segment/DP outputs active-low
DIG_ACTIVE_LOW, 1, 1 = digit enables active-low

Ports:
i_Clk  input  1  system clock; only clock
i_Rst  input  1  reset, asynchronous, active-high
i_Value  input  4*NUM_DIGITS  packed nibbles; nibble k = digit k, digit 0 rightmost
i_Dp  input  NUM_DIGITS  decimal point per digit
i_Load  input  1  one-cycle strobe; captures i_Value/i_Dp into shadow register
i_Hex_En  input  1  1 = decode 10-15 as A,b,C,d,E,F; 0 = blank 10-15
i_Blank_Lz  input  1  1 = blank leading zeros
o_Segments  output  7  bit6 = A ... bit0 = G
o_Dp  output  1  decimal point of active digit
o_Digit_En  output  NUM_DIGITS  one-hot digit enable
o_Frame_Done  output  1  one-cycle pulse at frame start

Behaviour:
- Reset (async, no clock needed): prescaler=0, digit index=0, shadow and display registers=0; o_Segments/o_Dp at inactive level (all 0 if SEG_ACTIVE_LOW=0, else all 1); o_Digit_En all inactive; o_Frame_Done=0. Scan restarts at digit 0, prescaler 0 on release.
- Shadow register: loaded from i_Value/i_Dp on any edge with i_Load=1; holds otherwise.
- Prescaler p counts 0..CLKS_PER_DIGIT-1 then wraps. On wrap, index advances 0..NUM_DIGITS-1 then wraps to 0.
- Frame boundary = edge where p wraps and index==NUM_DIGITS-1. At that edge, display register <= shadow register as it stood before the edge. A load on the same edge lands in shadow and is displayed next frame. Display never changes mid-frame.
- Decode (active-high form): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111. Codes 10-15 with i_Hex_En=0 give 0000000. Every code is fully specified; no held or latched values.
- Leading-zero blank: digit k>0 is blanked (segments off) when i_Blank_Lz=1 and display nibbles NUM_DIGITS-1..k are all zero. Digit 0 is never blanked by this rule. DP is unaffected by blanking.
- Output stage: all outputs are registered, 1-cycle latency from (index, p, display reg, i_Hex_En, i_Blank_Lz). o_Segments, o_Dp and o_Digit_En update on the same edge.
- o_Digit_En[index] is active only when p >= DEAD_CLKS, otherwise all inactive. Segments are driven throughout the slot.
- Output polarity is applied last: invert segments/DP when SEG_ACTIVE_LOW=1, invert enables when DIG_ACTIVE_LOW=1.
- o_Frame_Done is high for exactly one cycle: the cycle after the frame-boundary edge. Period is NUM_DIGITS*CLKS_PER_DIGIT.
- NUM_DIGITS=1: index is fixed at 0; every prescaler wrap is a frame boundary.

Test Plan:
(All with NUM_DIGITS=4, CLKS_PER_DIGIT=4, DEAD_CLKS=1, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1.)
- Reset asserted: o_Segments=0000000, o_Dp=0, o_Digit_En=4'b1111, o_Frame_Done=0; holds for 10 clocks.
- i_Load with i_Value=16'h1234, i_Dp=4'b0100, decimal mode -> after next o_Frame_Done: digit0 slot shows 0110011, digit1 1111001, digit2 1101101 with o_Dp=1, digit3 0110000. Each enable is low for 3 of 4 clocks (4'b1110, 4'b1101, ...); the first slot clock is 4'b1111.
- i_Value=16'hABCD: i_Hex_En=1 -> digit0=0111101, digit3=1110111; i_Hex_En=0 -> all slots 0000000 with enables still cycling.
- i_Blank_Lz=1: 16'h0050 -> digits 3,2 = 0000000, digit1=1011011, digit0=1111110. 16'h0000 -> only digit0 shows 1111110.
- Load 16'h1111 mid-frame (digit 1 slot), then 16'h2222 on the frame-boundary edge -> current frame unchanged; next frame shows 1111; 2222 appears the frame after. o_Frame_Done pulses every 16 cycles.
- Async i_Rst pulse mid-slot (digit 2, p=2), no clock edge -> outputs go inactive immediately. After release, the first enabled digit is digit 0 at clock 2; display shows 0.
